bcd_step_counter: RTL
=====================

# bcd_step_counter

Two-digit BCD counter that generates the digit pairs displayed by the binary-to-BCD/seven-segment stage. It advances on a prescaled timebase or on a manual step pulse, loads a 4-bit switch value converted to BCD, and wraps at a programmable modulus. Its `tens`/`ones` outputs connect directly to the two `bcd_7seg` decoders driving HEX1/HEX0.

## Interface
- `DIV`, default 50_000_000: prescaler period in clock cycles, ≥2.
- `MODULUS`, default 100: count range 0..MODULUS-1, 2..100.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: run enable for prescaled counting.
- `step` in 1: manual advance, synchronous level; rising edge counts.
- `load` in 1: load request.
- `load_val` in 4: binary value 0..15 to load.
- `dir` in 1: 0 = up, 1 = down. Used only when `BCD_CNT_DOWN_EN` is defined; ignored otherwise.
- `tens` out 4: BCD tens digit.
- `ones` out 4: BCD ones digit.
- `tick` out 1: prescaler terminal-count strobe.
- `carry` out 1: one-cycle wrap/borrow pulse.

## Operation
- **Reset:** `tens`, `ones`, `carry`, `tick`, prescaler count and step-history register all 0. Reset is asynchronous and can occur mid-count; there is no partial state on release.
- **Prescaler:**
  - Counts 0..DIV-1 while `en`=1 and `tick`=1 when the count is DIV-1; the count then returns to 0.
  - `en`=0 holds the prescaler at 0 and `tick`=0.
  - `load` also clears the prescaler.
- **Step detection:** `step_edge` = `step` & ~`step_d`, where `step_d` is `step` registered.
- **Advance event:** `tick` | `step_edge`. If both occur in the same cycle, the counter advances by exactly one.
- **Priority:** `load` > advance > hold.
- **Load conversion:**
  - `load_val` ≤ 9: tens = 0, ones = `load_val`.
  - `load_val` 10..15: tens = 1, ones = `load_val` − 10.
  - Loaded value ≥ MODULUS: load 00.
  - `carry`=0 on a load cycle.
- **Up count:**
  - ones < 9: ones + 1.
  - ones = 9: ones = 0, tens + 1.
  - Value MODULUS−1: 00, and `carry` pulses.
- **Down count** (macro only):
  - ones > 0: ones − 1.
  - ones = 0: ones = 9, tens − 1.
  - Value 00: MODULUS−1 in BCD, and `carry` pulses (borrow).
- **Invariants:** digits never leave 0..9; the count is never ≥ MODULUS.

## Timing
- All outputs are registered except `tick`, which is decoded combinationally from the prescaler register.
- **Load:** `load` sampled high at edge N → digits valid after edge N (latency 1).
- **Step:** `step` first sampled high at edge N (low at N−1) → digits change after edge N. Holding `step` high gives a single advance.
- **Prescaled rate:** with `en` held high from reset, the first advance occurs at edge DIV; subsequent advances occur every DIV cycles.
- **Carry:** high for exactly the one cycle following the wrapping edge. Consecutive wraps (MODULUS=2 with continuous steps) give separate pulses.
- **`en` deassert mid-period:** the partial prescaler count is discarded; the next period restarts at 0.

## Configuration
- **`BCD_CNT_DOWN_EN` defined:** `dir` selects direction per advance event; the down/borrow logic is compiled in.
- **Not defined:** up-count only. `dir` stays in the port list but is unconnected internally; there is no down logic.

## Structure
- **Package `bcd_pkg`:**
  - typedef `bcd_digit_t` (4-bit).
  - constants `BCD_MAX` = 9 and `BCD_ZERO` = 0.
  - the function converting binary 0..15 to a `{tens, ones}` pair, shared with the display stage.
- **Sub-module `tick_gen`:** the prescaler, parameterised by `DIV`, with inputs `clk`, `rst`, `en`, `clr` and output `tick`.
- **Top:** `bcd_step_counter` contains the step edge detector, the load mux and the digit counter.

## Test plan
- **Reset mid-count:** assert `rst` asynchronously at count 47 → `tens`=0, `ones`=0, `carry`=0 immediately; after release with DIV=4 and `en`=1, first advance at edge 4.
- **Prescaled counting:** DIV=4, `en`=1 for 40 cycles → count 10 (tens=1, ones=0); `tick` high exactly once per 4 cycles.
- **Up wrap:** `step` pulses from 98, MODULUS=100 → 99, then 00 with `carry` high for one cycle.
- **Load:** `load_val`=13 → tens=1, ones=3. With MODULUS=10, `load_val`=13 → 00.
- **Simultaneous load and step:** `load` with `load_val`=5 and `step` rising edge in the same cycle → 05, no advance. Simultaneous `tick` and step edge → advance by one only.
- **Down wrap** (`BCD_CNT_DOWN_EN`, MODULUS=60): `dir`=1, step from 00 → 59 with `carry` pulse; step from 10 → 09.

Source files
------------

// File: rtl/bcd_step_counter_pkg.sv
// Shared BCD types, digit constants and the binary-to-BCD helper
// used by the step counter and the seven-segment display stage.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef struct packed {
      bcd_digit_t tens;
      bcd_digit_t ones;
   } bcd_pair_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   function automatic bcd_pair_t bin_to_bcd(input logic [3:0] bin);
      bcd_pair_t r;
      if (bin > 4'd9) begin
         r.tens = 4'd1;
         r.ones = bin - 4'd10;
      end else begin
         r.tens = BCD_ZERO;
         r.ones = bin;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_step_counter_if.sv
// Control and digit bus of the BCD step counter; master drives the controls,
// slave (the counter) drives digits, tick and carry.
interface bcd_step_counter_if;

   logic                 en;
   logic                 step;
   logic                 load;
   logic [3:0]           load_val;
   logic                 dir;
   bcd_pkg::bcd_digit_t  tens;
   bcd_pkg::bcd_digit_t  ones;
   logic                 tick;
   logic                 carry;

   modport master (
      output en, step, load, load_val, dir,
      input  tens, ones, tick, carry
   );

   modport slave (
      input  en, step, load, load_val, dir,
      output tens, ones, tick, carry
   );

endinterface

// File: rtl/bcd_step_counter_tick_gen.sv
// Prescaler: counts 0..DIV-1 while enabled, tick decoded from the count register.
// Disable or clr returns the count to 0 on the next edge; no backpressure.
module tick_gen #(
   parameter int DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = en & (cnt_q == LAST);

   // A partial period is discarded whenever the prescaler is disabled or cleared.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!en || clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/bcd_step_counter.sv
// Two-digit BCD counter with prescaled/manual advance, binary load and modulus wrap; 1-cycle latency.
// Optional down counting via BCD_CNT_DOWN_EN; no backpressure, load beats advance beats hold.
module bcd_step_counter
   import bcd_pkg::*;
#(
   parameter int DIV     = 50_000_000,
   parameter int MODULUS = 100
) (
   input  logic                clk,
   input  logic                rst,
   bcd_step_counter_if.slave   bus
);

   localparam bcd_digit_t TOP_TENS = bcd_digit_t'((MODULUS - 1) / 10);
   localparam bcd_digit_t TOP_ONES = bcd_digit_t'((MODULUS - 1) % 10);

   logic       tick;
   logic       step_q, step_d;
   logic       carry_q, carry_d;
   bcd_digit_t tens_q, tens_d;
   bcd_digit_t ones_q, ones_d;
   logic       step_edge;
   logic       advance;
   logic       at_top;
   bcd_pair_t  ld;

   tick_gen #(
      .DIV (DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (bus.en),
      .clr  (bus.load),
      .tick (tick)
   );

   assign bus.tick  = tick;
   assign bus.tens  = tens_q;
   assign bus.ones  = ones_q;
   assign bus.carry = carry_q;

`ifndef BCD_CNT_DOWN_EN
   logic unused_dir;
   assign unused_dir = bus.dir;
`endif

   always_comb begin
      step_d    = bus.step;
      step_edge = bus.step & ~step_q;
      advance   = tick | step_edge;
      at_top    = (tens_q == TOP_TENS) && (ones_q == TOP_ONES);
      ld        = bin_to_bcd(bus.load_val);
      tens_d    = tens_q;
      ones_d    = ones_q;
      carry_d   = 1'b0;

      if (bus.load) begin
         // Loaded values outside the count range collapse to 00.
         if (int'(bus.load_val) >= MODULUS) begin
            tens_d = BCD_ZERO;
            ones_d = BCD_ZERO;
         end else begin
            tens_d = ld.tens;
            ones_d = ld.ones;
         end
      end else if (advance) begin
`ifdef BCD_CNT_DOWN_EN
         if (bus.dir) begin
            if (tens_q == BCD_ZERO && ones_q == BCD_ZERO) begin
               tens_d  = TOP_TENS;
               ones_d  = TOP_ONES;
               carry_d = 1'b1;
            end else if (ones_q == BCD_ZERO) begin
               ones_d = BCD_MAX;
               tens_d = tens_q - 4'd1;
            end else begin
               ones_d = ones_q - 4'd1;
            end
         end else
`endif
         begin
            if (at_top) begin
               tens_d  = BCD_ZERO;
               ones_d  = BCD_ZERO;
               carry_d = 1'b1;
            end else if (ones_q == BCD_MAX) begin
               ones_d = BCD_ZERO;
               tens_d = tens_q + 4'd1;
            end else begin
               ones_d = ones_q + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q  <= 1'b0;
         carry_q <= 1'b0;
         tens_q  <= BCD_ZERO;
         ones_q  <= BCD_ZERO;
      end else begin
         step_q  <= step_d;
         carry_q <= carry_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
      end
   end

endmodule
